// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage hazard inputs and forwarding/stall outputs of the hazard controller.
interface hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_ADDR_W-1:0] rs1_s1, rs2_s1, rd_s1;
    logic use_rs1_s1, use_rs2_s1, reg_wr_s1, mem_rd_s1;
    logic branch_s1, branch_taken_s1, freeze;
    logic [1:0] forward_A, forward_B, forward_C, forward_D;
    logic stall_s1, bubble_s2, flush_s1;
    logic [CNT_W-1:0] hazard_stalls;

    modport master (
        output rs1_s1, rs2_s1, rd_s1, use_rs1_s1, use_rs2_s1, reg_wr_s1, mem_rd_s1,
        output branch_s1, branch_taken_s1, freeze,
        input forward_A, forward_B, forward_C, forward_D, stall_s1, bubble_s2, flush_s1, hazard_stalls
    );
    modport slave (
        input rs1_s1, rs2_s1, rd_s1, use_rs1_s1, use_rs2_s1, reg_wr_s1, mem_rd_s1,
        input branch_s1, branch_taken_s1, freeze,
        output forward_A, forward_B, forward_C, forward_D, stall_s1, bubble_s2, flush_s1, hazard_stalls
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage hazard unit; EX/MEM/WB destination scoreboard driving
// forwarding selects, load-use and branch-in-decode stalls, fetch flush and a stall counter.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst_n,
    hazard_if.slave hz
);
    typedef struct packed {
        logic wr;
        logic [REG_ADDR_W-1:0] rd;
        logic ld;
    } entry_t;

    entry_t e2, e3, e4;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stalls;
    logic m2_1, m2_2, m3_1, m3_2, m4_1, m4_2, hazard;

    function automatic logic match(entry_t e, logic [REG_ADDR_W-1:0] r, logic en);
        return en & e.wr & (e.rd == r);
    endfunction

    assign m2_1 = match(e2, hz.rs1_s1, hz.use_rs1_s1);
    assign m2_2 = match(e2, hz.rs2_s1, hz.use_rs2_s1);
    assign m3_1 = match(e3, hz.rs1_s1, hz.use_rs1_s1);
    assign m3_2 = match(e3, hz.rs2_s1, hz.use_rs2_s1);
    assign m4_1 = match(e4, hz.rs1_s1, hz.use_rs1_s1);
    assign m4_2 = match(e4, hz.rs2_s1, hz.use_rs2_s1);

    // An EX producer blocks loads' consumers and any decode-resolved branch; a MEM load blocks only branches.
    assign hazard = ((m2_1 | m2_2) & (e2.ld | hz.branch_s1)) | (hz.branch_s1 & e3.ld & (m3_1 | m3_2));

    assign hz.stall_s1 = hazard & ~hz.freeze;
    assign hz.bubble_s2 = hazard & ~hz.freeze;
    assign hz.flush_s1 = hz.branch_s1 & hz.branch_taken_s1 & ~hazard & ~hz.freeze;
    assign hz.forward_C = (m3_1 & ~e3.ld) ? 2'b01 : m4_1 ? 2'b10 : 2'b00;
    assign hz.forward_D = (m3_2 & ~e3.ld) ? 2'b01 : m4_2 ? 2'b10 : 2'b00;
    assign hz.forward_A = fwd_a;
    assign hz.forward_B = fwd_b;
    assign hz.hazard_stalls = stalls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e2 <= '0;
            e3 <= '0;
            e4 <= '0;
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
            stalls <= '0;
        end else if (!hz.freeze) begin
            e4 <= e3;
            e3 <= e2;
            e2 <= hazard ? '0 : entry_t'{wr: hz.reg_wr_s1 & (hz.rd_s1 != '0), rd: hz.rd_s1, ld: hz.mem_rd_s1};
            fwd_a <= hazard ? 2'b00 : m2_1 ? 2'b01 : m3_1 ? 2'b10 : 2'b00;
            fwd_b <= hazard ? 2'b00 : m2_2 ? 2'b01 : m3_2 ? 2'b10 : 2'b00;
            if (hazard && !(&stalls)) stalls <= stalls + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus random traffic, scored against a
// pipeline-occupancy model; a narrow counter makes saturation reachable.
module tb_hazard_ctrl;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] fa, fb, fc, fd, cnt;
        bit stall, flush;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    hazard_if #(.REG_ADDR_W(5), .CNT_W(CW)) hz ();
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));

    always #5 clk = ~clk;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int dst[2:4];
    bit ldm[2:4];
    int fa, fb, cnt;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask

    function automatic bit prod(int k, int r, bit u);
        return u && r != 0 && dst[k] == r;
    endfunction

    function automatic int ex_sel(int r, bit u, bit haz);
        if (haz) return 0;
        if (prod(2, r, u)) return 1;
        if (prod(3, r, u)) return 2;
        return 0;
    endfunction

    function automatic int br_sel(int r, bit u);
        if (prod(3, r, u) && !ldm[3]) return 1;
        if (prod(4, r, u)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 2; k <= 4; k++) begin
            dst[k] = 0;
            ldm[k] = 0;
        end
        fa = 0;
        fb = 0;
        cnt = 0;
    endtask

    task automatic step(input bit r, fr, input int rs1, rs2, input bit u1, u2,
                        input int rd, input bit wr, ld, br, tk);
        exp_t e;
        bit haz;
        rst_n = r;
        hz.freeze = fr;
        hz.rs1_s1 = 5'(rs1);
        hz.rs2_s1 = 5'(rs2);
        hz.use_rs1_s1 = u1;
        hz.use_rs2_s1 = u2;
        hz.rd_s1 = 5'(rd);
        hz.reg_wr_s1 = wr;
        hz.mem_rd_s1 = ld;
        hz.branch_s1 = br;
        hz.branch_taken_s1 = tk;
        haz = 0;
        for (int s = 0; s < 2; s++) begin
            int rr = s ? rs2 : rs1;
            bit uu = s ? u2 : u1;
            if (prod(2, rr, uu) && (br || ldm[2])) haz = 1;
            if (br && prod(3, rr, uu) && ldm[3]) haz = 1;
        end
        e.stall = haz && !fr;
        e.flush = br && tk && !haz && !fr;
        e.fa = fa;
        e.fb = fb;
        e.cnt = cnt;
        e.fc = br_sel(rs1, u1);
        e.fd = br_sel(rs2, u2);
        q.push_back(e);
        if (!r) model_reset();
        else if (!fr) begin
            if (e.stall && cnt < CMAX) cnt++;
            fa = ex_sel(rs1, u1, haz);
            fb = ex_sel(rs2, u2, haz);
            dst[4] = dst[3];
            ldm[4] = ldm[3];
            dst[3] = dst[2];
            ldm[3] = ldm[2];
            dst[2] = (haz || !wr) ? 0 : rd;
            ldm[2] = !haz && ld;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("forward_A", 32'(hz.forward_A), e.fa);
                chk("forward_B", 32'(hz.forward_B), e.fb);
                chk("stall_s1", 32'(hz.stall_s1), 32'(e.stall));
                chk("bubble_s2", 32'(hz.bubble_s2), 32'(e.stall));
                chk("flush_s1", 32'(hz.flush_s1), 32'(e.flush));
                chk("hazard_stalls", 32'(hz.hazard_stalls), e.cnt);
                if (!e.stall) begin
                    chk("forward_C", 32'(hz.forward_C), e.fc);
                    chk("forward_D", 32'(hz.forward_D), e.fd);
                end
            end
        end
    end

    initial begin
        hz.freeze = 0;
        hz.rs1_s1 = 0;
        hz.rs2_s1 = 0;
        hz.use_rs1_s1 = 0;
        hz.use_rs2_s1 = 0;
        hz.rd_s1 = 0;
        hz.reg_wr_s1 = 0;
        hz.mem_rd_s1 = 0;
        hz.branch_s1 = 0;
        hz.branch_taken_s1 = 0;
        @(posedge clk);
        #1;
        model_reset();
        nop();
        // back-to-back ALU, then one independent instruction between
        step(1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0);
        step(1, 0, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 8, 1, 0, 0, 0);
        step(1, 0, 7, 0, 1, 0, 9, 1, 0, 0, 0);
        nop();
        // load-use
        step(1, 0, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        repeat (2) step(1, 0, 5, 0, 1, 1, 6, 1, 0, 0, 0);
        nop();
        nop();
        // branch after ALU, taken
        step(1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0);
        repeat (2) step(1, 0, 5, 0, 1, 1, 0, 0, 0, 1, 1);
        nop();
        // branch after load
        step(1, 0, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        repeat (3) step(1, 0, 5, 6, 1, 1, 0, 0, 0, 1, 1);
        nop();
        nop();
        // writes to x0
        step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 6, 1, 0, 0, 0);
        nop();
        // freeze during load-use
        step(1, 0, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        repeat (3) step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        repeat (2) step(1, 0, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        nop();
        // reset mid-stall
        step(1, 0, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        step(0, 0, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        step(1, 0, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99) != 0, $urandom_range(7) == 0,
                 $urandom_range(3), $urandom_range(3), $urandom_range(3) != 0, $urandom_range(1),
                 $urandom_range(3), $urandom_range(3) != 0, $urandom_range(2) == 0,
                 $urandom_range(2) == 0, $urandom_range(1));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
